// File: rtl/digit_accum_if.sv
// Key-entry and result handshake bundle for digit_accum.
// The keypad side drives through 'master'; the accumulator uses 'slave'.
interface digit_accum_if #(
    parameter int NDIG = 2
) ();
    localparam int OUT_W = 4 * NDIG;
    localparam int CNT_W = $clog2(NDIG + 1);

    logic             key_vld;
    logic [4:0]       key_code;
    logic             mode;
    logic             key_rdy;
    logic [OUT_W-1:0] value;
    logic [CNT_W-1:0] cnt;
    logic             out_vld;
    logic             out_rdy;
    logic             ovf;
    logic             err;

    modport master (
        output key_vld, key_code, mode, out_rdy,
        input  key_rdy, value, cnt, out_vld, ovf, err
    );

    modport slave (
        input  key_vld, key_code, mode, out_rdy,
        output key_rdy, value, cnt, out_vld, ovf, err
    );
endinterface

// File: rtl/digit_accum.sv
// Keypad digit accumulator: shifts key digits into NDIG nibbles, shows hex or decimal value.
// Optional backspace key enabled by defining DIGIT_ACCUM_BKSP_EN.
module digit_accum #(
    parameter int         NDIG     = 2,
    parameter logic [4:0] ENT_CODE = 5'd29,
    parameter logic [4:0] CLR_CODE = 5'd30,
    parameter logic [4:0] BSP_CODE = 5'd31
) (
    input  logic          clk,
    input  logic          rst,
    digit_accum_if.slave  bus
);
    localparam int             OUT_W = 4 * NDIG;
    localparam int             CNT_W = $clog2(NDIG + 1);
    localparam logic [OUT_W-1:0] TEN  = OUT_W'(10);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NDIG);

    typedef enum logic {ENTRY = 1'b0, DONE = 1'b1} state_t;

    state_t                 state, state_n;
    logic [NDIG-1:0][3:0]   dig_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   mode_r;
    logic                   ovf_r;
    logic                   err_r;

    logic                   empty, full, eff_mode, is_digit, is_bsp;
    logic                   do_shift, do_clr, do_bksp, set_ovf, err_n;

    // Horner evaluation, most significant digit first.
    function automatic logic [OUT_W-1:0] dec_value(input logic [NDIG-1:0][3:0] d);
        logic [OUT_W-1:0] acc;
        acc = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            acc = OUT_W'(acc * TEN) + OUT_W'(d[k]);
        end
        return acc;
    endfunction

    assign empty    = (cnt_r == '0);
    assign full     = (cnt_r == FULL);
    // The first digit of an entry is judged by the mode it is about to latch.
    assign eff_mode = empty ? bus.mode : mode_r;
    assign is_digit = eff_mode ? (bus.key_code < 5'd10) : (bus.key_code < 5'd16);
    assign is_bsp   = (bus.key_code == BSP_CODE);

    always_ff @(posedge clk) begin
        if (rst) state <= ENTRY;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        do_clr   = 1'b0;
        do_bksp  = 1'b0;
        set_ovf  = 1'b0;
        err_n    = 1'b0;
        case (state)
            ENTRY: begin
                if (bus.key_vld) begin
                    if (is_digit) begin
                        if (full) set_ovf  = 1'b1;
                        else      do_shift = 1'b1;
                    end else if (bus.key_code == CLR_CODE) begin
                        do_clr = 1'b1;
                    end else if (bus.key_code == ENT_CODE) begin
                        if (empty) err_n   = 1'b1;
                        else       state_n = DONE;
                    end else if (is_bsp) begin
`ifdef DIGIT_ACCUM_BKSP_EN
                        if (empty) err_n   = 1'b1;
                        else       do_bksp = 1'b1;
`else
                        err_n = 1'b1;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_rdy) begin
                    do_clr  = 1'b1;
                    state_n = ENTRY;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_r  <= '0;
            cnt_r  <= '0;
            mode_r <= 1'b0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            err_r <= err_n;
            if (set_ovf) ovf_r <= 1'b1;
            if (do_shift) begin
                for (int k = NDIG - 1; k > 0; k--) dig_r[k] <= dig_r[k-1];
                dig_r[0] <= bus.key_code[3:0];
                cnt_r    <= cnt_r + CNT_W'(1);
                if (empty) mode_r <= bus.mode;
            end
            if (do_bksp) begin
                for (int k = 0; k < NDIG - 1; k++) dig_r[k] <= dig_r[k+1];
                dig_r[NDIG-1] <= 4'd0;
                cnt_r         <= cnt_r - CNT_W'(1);
                ovf_r         <= 1'b0;
            end
            if (do_clr) begin
                dig_r <= '0;
                cnt_r <= '0;
                ovf_r <= 1'b0;
            end
        end
    end

    assign bus.value   = mode_r ? dec_value(dig_r) : OUT_W'(dig_r);
    assign bus.cnt     = cnt_r;
    assign bus.key_rdy = (state == ENTRY);
    assign bus.out_vld = (state == DONE);
    assign bus.ovf     = ovf_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_digit_accum.sv
// Bench for digit_accum: directed scenarios then random key streams against a queue-based model.
// Honours DIGIT_ACCUM_BKSP_EN the same way the design does.
module tb_digit_accum;
    localparam int NDIG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    digit_accum_if #(.NDIG(NDIG)) bus ();

    digit_accum #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: digits as a queue, q[0] least significant.
    int q[$];
    bit m_done, m_ovf, m_err, m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_value();
        int v = 0;
        int base = m_mode ? 10 : 16;
        for (int k = q.size() - 1; k >= 0; k--) v = v * base + q[k];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit vld, input int code, input bit md, input bit ordy);
        bit e = 0;
        if (r) begin
            q.delete();
            m_done = 0; m_ovf = 0; m_mode = 0;
        end else if (!m_done) begin
            if (vld) begin
                int lim = ((q.size() == 0) ? md : m_mode) ? 10 : 16;
                if (code < lim) begin
                    if (q.size() == NDIG) m_ovf = 1;
                    else begin
                        if (q.size() == 0) m_mode = md;
                        q.push_front(code);
                    end
                end else if (code == 30) begin
                    q.delete(); m_ovf = 0;
                end else if (code == 29) begin
                    if (q.size() == 0) e = 1; else m_done = 1;
                end else if (code == 31) begin
`ifdef DIGIT_ACCUM_BKSP_EN
                    if (q.size() == 0) e = 1;
                    else begin
                        void'(q.pop_front());
                        m_ovf = 0;
                    end
`else
                    e = 1;
`endif
                end else e = 1;
            end
        end else if (ordy) begin
            q.delete(); m_ovf = 0; m_done = 0;
        end
        m_err = e;
    endtask

    task automatic cyc(input bit r, input bit vld, input int code, input bit md, input bit ordy);
        @(negedge clk);
        rst          = r;
        bus.key_vld  = vld;
        bus.key_code = 5'(code);
        bus.mode     = md;
        bus.out_rdy  = ordy;
        @(posedge clk);
        model_step(r, vld, code, md, ordy);
        #1;
        check("value",   32'(bus.value),   32'(model_value()));
        check("cnt",     32'(bus.cnt),     32'(q.size()));
        check("key_rdy", 32'(bus.key_rdy), 32'(!m_done));
        check("out_vld", 32'(bus.out_vld), 32'(m_done));
        check("ovf",     32'(bus.ovf),     32'(m_ovf));
        check("err",     32'(bus.err),     32'(m_err));
    endtask

    task automatic key(input int code, input bit md);
        cyc(1'b0, 1'b1, code, md, 1'b0);
    endtask

    initial begin
        bus.key_vld = 0; bus.key_code = 0; bus.mode = 0; bus.out_rdy = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 1);
        check("rst_value", 32'(bus.value), 0);
        check("rst_rdy",   32'(bus.key_rdy), 1);

        // hex entry and commit
        key(1, 0); key(2, 0); key(29, 0);
        check("t1_value", 32'(bus.value), 32'h12);
        check("t1_vld",   32'(bus.out_vld), 1);
        cyc(0, 0, 0, 0, 1);
        check("t1_clear", 32'(bus.value), 0);

        // decimal entry, illegal digit
        key(4, 1); key(2, 1);
        check("t2_dec", 32'(bus.value), 42);
        key(12, 1);
        check("t2_err", 32'(bus.err), 1);
        check("t2_keep", 32'(bus.value), 42);
        key(30, 0);

        // overflow and clear
        key(3, 0); key(4, 0); key(5, 0);
        check("t3_value", 32'(bus.value), 32'h34);
        check("t3_ovf",   32'(bus.ovf), 1);
        key(30, 0);
        check("t3_clr", 32'(bus.ovf), 0);

        // ENT on empty, keys ignored while DONE
        key(29, 0);
        check("t4_err", 32'(bus.err), 1);
        key(1, 0); key(29, 0); key(5, 0); key(12, 0); key(29, 0);
        check("t4_noerr", 32'(bus.err), 0);
        check("t4_hold",  32'(bus.value), 1);
        cyc(0, 0, 0, 0, 1);

        // mode is latched on the first digit only
        key(7, 1); key(9, 0);
        check("t5_dec", 32'(bus.value), 79);
        key(30, 0);

        // backspace, then reset while DONE
        key(1, 0); key(2, 0); key(31, 0);
`ifdef DIGIT_ACCUM_BKSP_EN
        check("t6_bsp", 32'(bus.value), 32'h01);
`else
        check("t6_bsp", 32'(bus.err), 1);
`endif
        key(29, 0);
        cyc(1, 0, 0, 0, 0);
        check("t6_rst", 32'(bus.out_vld), 0);

        for (int i = 0; i < 2000; i++) begin
            int sel = $urandom_range(0, 9);
            int code;
            if (sel <= 5)      code = $urandom_range(0, 15);
            else if (sel == 6) code = 29;
            else if (sel == 7) code = 30;
            else if (sel == 8) code = 31;
            else               code = $urandom_range(16, 28);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), code,
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
